// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the register file's single write port between in-order pipeline
// writeback and a long-latency unit (divider, HI/LO, cache-miss load return).
//
// Behaviour summary:
//   - Pipeline writeback always wins the port and is never stalled.
//   - One long-latency result is buffered and written on the first cycle the
//     pipeline leaves the port idle.
//   - A scoreboard of destinations with outstanding long-latency writes drives
//     the decode hazard stall.
//   - A starvation counter requests a pipeline bubble when the buffered result
//     keeps losing arbitration.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pipe_valid_i/addr_i/data_i     pipeline writeback (always accepted)
//   lu_valid_i/addr_i/data_i       long-latency result offer
//   lu_ready_o                     buffer can accept a long-latency result
//   issue_i, issue_addr_i          long-latency op issue and its destination
//   issue_ok_o                     destination is not already pending
//   chk_en1_i/addr1_i              decode source operand 1 check
//   chk_en2_i/addr2_i              decode source operand 2 check
//   chk_dst_en_i, chk_dst_i        decode destination check
//   stall_o                        decode hazard on a pending register
//   drain_req_o                    request one pipeline writeback bubble
//   we_o, waddr_o, wdata_o         register file write port
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid_i,
  input  logic [4:0]  pipe_addr_i,
  input  logic [31:0] pipe_data_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_addr_i,
  input  logic [31:0] lu_data_i,
  output logic        lu_ready_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_addr_i,
  output logic        issue_ok_o,
  input  logic        chk_en1_i,
  input  logic [4:0]  chk_addr1_i,
  input  logic        chk_en2_i,
  input  logic [4:0]  chk_addr2_i,
  input  logic        chk_dst_en_i,
  input  logic [4:0]  chk_dst_i,
  output logic        stall_o,
  output logic        drain_req_o,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o
);

  localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);
  localparam logic [3:0] LP_STARVE_MAX   = 4'hF;

  // Buffered long-latency result.
  logic        r_buf_valid;
  logic [4:0]  r_buf_addr;
  logic [31:0] r_buf_data;

  // Scoreboard; bit 0 is never set, so r0 can never be pending.
  logic [31:0] r_pending;

  // Consecutive cycles the buffered result has lost the port.
  logic [3:0]  r_starve;

  logic        w_buf_grant;
  logic        w_lu_accept;
  logic        w_issue_set;
  logic [31:0] w_clr_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_pend_eff;

  // The buffer only gets the port when the pipeline leaves it idle.
  assign w_buf_grant = !rst && r_buf_valid && !pipe_valid_i;

  // A full buffer can still accept when it drains on this same edge.
  assign lu_ready_o  = !rst && (!r_buf_valid || w_buf_grant);
  assign w_lu_accept = lu_valid_i && lu_ready_o;

  assign issue_ok_o  = rst || (issue_addr_i == 5'd0) || !r_pending[issue_addr_i];
  assign w_issue_set = issue_i && issue_ok_o && (issue_addr_i != 5'd0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the if/else leaves it unassigned and infers a latch.
    we_o    = 1'b0;
    waddr_o = 5'd0;
    wdata_o = 32'd0;
    if (!rst) begin
      if (pipe_valid_i) begin
        we_o    = 1'b1;
        waddr_o = pipe_addr_i;
        wdata_o = pipe_data_i;
      end else if (r_buf_valid) begin
        we_o    = 1'b1;
        waddr_o = r_buf_addr;
        wdata_o = r_buf_data;
      end
    end
  end

  always_comb begin
    w_clr_mask = 32'd0;
    w_set_mask = 32'd0;
    if (w_buf_grant && (r_buf_addr != 5'd0)) w_clr_mask[r_buf_addr] = 1'b1;
    if (w_issue_set) w_set_mask[issue_addr_i] = 1'b1;
  end

  // The register being written this cycle reaches decode through the
  // register file write bypass, so it no longer needs to stall.
  assign w_pend_eff = r_pending & ~w_clr_mask;

  assign stall_o = !rst && ((chk_en1_i    && w_pend_eff[chk_addr1_i]) ||
                            (chk_en2_i    && w_pend_eff[chk_addr2_i]) ||
                            (chk_dst_en_i && w_pend_eff[chk_dst_i]));

  assign drain_req_o = !rst && r_buf_valid && (r_starve >= LP_STARVE_LIMIT);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the scoreboard is reset even though it is array-like state; a
      // stale pending bit would stall decode forever. The buffer payload is
      // qualified by r_buf_valid and needs no reset.
      r_buf_valid <= 1'b0;
      r_pending   <= 32'd0;
      r_starve    <= 4'd0;
    end else begin
      if (w_lu_accept) begin
        r_buf_valid <= 1'b1;
        r_buf_addr  <= lu_addr_i;
        r_buf_data  <= lu_data_i;
      end else if (w_buf_grant) begin
        r_buf_valid <= 1'b0;
      end

      // Set and clear never target the same register: issue_ok_o is low
      // for a pending destination.
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;

      // A valid buffer that is not granted has necessarily lost to the pipe.
      if (!r_buf_valid || w_buf_grant) begin
        r_starve <= 4'd0;
      end else if (r_starve != LP_STARVE_MAX) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid_i;
  logic [4:0]  pipe_addr_i;
  logic [31:0] pipe_data_i;
  logic        lu_valid_i;
  logic [4:0]  lu_addr_i;
  logic [31:0] lu_data_i;
  logic        lu_ready_o;
  logic        issue_i;
  logic [4:0]  issue_addr_i;
  logic        issue_ok_o;
  logic        chk_en1_i;
  logic [4:0]  chk_addr1_i;
  logic        chk_en2_i;
  logic [4:0]  chk_addr2_i;
  logic        chk_dst_en_i;
  logic [4:0]  chk_dst_i;
  logic        stall_o;
  logic        drain_req_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b1;

  localparam int LIMIT = 4;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid_i(pipe_valid_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
    .lu_valid_i(lu_valid_i), .lu_addr_i(lu_addr_i), .lu_data_i(lu_data_i),
    .lu_ready_o(lu_ready_o),
    .issue_i(issue_i), .issue_addr_i(issue_addr_i), .issue_ok_o(issue_ok_o),
    .chk_en1_i(chk_en1_i), .chk_addr1_i(chk_addr1_i),
    .chk_en2_i(chk_en2_i), .chk_addr2_i(chk_addr2_i),
    .chk_dst_en_i(chk_dst_en_i), .chk_dst_i(chk_dst_i),
    .stall_o(stall_o), .drain_req_o(drain_req_o),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one optional held result, a set of pending registers,
  // and a count of consecutive lost arbitrations.
  // ---------------------------------------------------------------------------
  bit          m_held = 1'b0;
  logic [4:0]  m_held_addr = 5'd0;
  logic [31:0] m_held_data = 32'd0;
  bit          m_pend [32];
  int          m_losses = 0;

  task automatic model_step();
    bit port_free;
    bit ok;
    if (rst) begin
      m_held   = 1'b0;
      m_losses = 0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else begin
      port_free = m_held && !pipe_valid_i;
      ok = (issue_addr_i == 5'd0) || !m_pend[issue_addr_i];
      if (port_free && m_held_addr != 5'd0) m_pend[m_held_addr] = 1'b0;
      if (issue_i && ok && issue_addr_i != 5'd0) m_pend[issue_addr_i] = 1'b1;
      if (m_held && !port_free) m_losses = (m_losses < 15) ? m_losses + 1 : 15;
      else m_losses = 0;
      if (port_free) m_held = 1'b0;
      if (lu_valid_i && !m_held) begin
        m_held      = 1'b1;
        m_held_addr = lu_addr_i;
        m_held_data = lu_data_i;
      end
    end
  endtask

  function automatic bit hazard(input bit en, input logic [4:0] a, input bit port_free);
    return en && a != 5'd0 && m_pend[a] && !(port_free && a == m_held_addr);
  endfunction

  task automatic compare();
    bit          port_free;
    bit          e_we, e_rdy, e_ok, e_stall, e_drain;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    port_free = m_held && !pipe_valid_i;
    e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0;
    if (rst) begin
      e_rdy = 1'b0; e_ok = 1'b1; e_stall = 1'b0; e_drain = 1'b0;
    end else begin
      if (pipe_valid_i) begin
        e_we = 1'b1; e_addr = pipe_addr_i; e_data = pipe_data_i;
      end else if (m_held) begin
        e_we = 1'b1; e_addr = m_held_addr; e_data = m_held_data;
      end
      e_rdy   = !m_held || port_free;
      e_ok    = (issue_addr_i == 5'd0) || !m_pend[issue_addr_i];
      e_stall = hazard(chk_en1_i, chk_addr1_i, port_free) ||
                hazard(chk_en2_i, chk_addr2_i, port_free) ||
                hazard(chk_dst_en_i, chk_dst_i, port_free);
      e_drain = m_held && m_losses >= LIMIT;
    end
    check("mdl_we",       32'(we_o),        32'(e_we));
    check("mdl_waddr",    32'(waddr_o),     32'(e_addr));
    check("mdl_wdata",    wdata_o,          e_data);
    check("mdl_lu_ready", 32'(lu_ready_o),  32'(e_rdy));
    check("mdl_issue_ok", 32'(issue_ok_o),  32'(e_ok));
    check("mdl_stall",    32'(stall_o),     32'(e_stall));
    check("mdl_drain",    32'(drain_req_o), 32'(e_drain));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (run) compare();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations.
  // ---------------------------------------------------------------------------
  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic idle_in();
    rst = 1'b0;
    pipe_valid_i = 1'b0; pipe_addr_i = 5'd0; pipe_data_i = 32'd0;
    lu_valid_i = 1'b0; lu_addr_i = 5'd0; lu_data_i = 32'd0;
    issue_i = 1'b0; issue_addr_i = 5'd0;
    chk_en1_i = 1'b0; chk_addr1_i = 5'd0;
    chk_en2_i = 1'b0; chk_addr2_i = 5'd0;
    chk_dst_en_i = 1'b0; chk_dst_i = 5'd0;
  endtask

  initial begin
    idle_in();
    // Reset with both sources active.
    rst = 1'b1;
    pipe_valid_i = 1'b1; pipe_addr_i = 5'd2; pipe_data_i = 32'h22;
    lu_valid_i = 1'b1; lu_addr_i = 5'd1; lu_data_i = 32'h11;
    go();
    for (int c = 0; c < 2; c++) begin
      mid();
      check("rst_we", 32'(we_o), 32'd0);
      check("rst_lu_ready", 32'(lu_ready_o), 32'd0);
      check("rst_issue_ok", 32'(issue_ok_o), 32'd1);
      go();
    end

    // After release: empty buffer, every address issuable.
    idle_in();
    for (int a = 0; a < 32; a++) begin
      issue_addr_i = 5'(a);
      mid();
      check("post_rst_issue_ok", 32'(issue_ok_o), 32'd1);
      check("post_rst_lu_ready", 32'(lu_ready_o), 32'd1);
      check("post_rst_we", 32'(we_o), 32'd0);
      go();
    end

    // Idle-port drain of r5.
    idle_in();
    issue_i = 1'b1; issue_addr_i = 5'd5;
    mid(); check("r5_issue_ok", 32'(issue_ok_o), 32'd1);
    go();
    idle_in();
    lu_valid_i = 1'b1; lu_addr_i = 5'd5; lu_data_i = 32'hDEADBEEF;
    chk_en1_i = 1'b1; chk_addr1_i = 5'd5;
    mid();
    check("r5_stall_pending", 32'(stall_o), 32'd1);
    check("r5_we_before", 32'(we_o), 32'd0);
    go();
    lu_valid_i = 1'b0;
    mid();
    check("r5_we", 32'(we_o), 32'd1);
    check("r5_waddr", 32'(waddr_o), 32'd5);
    check("r5_wdata", wdata_o, 32'hDEADBEEF);
    check("r5_stall_bypass", 32'(stall_o), 32'd0);
    go();
    issue_addr_i = 5'd5;
    mid();
    check("r5_stall_after", 32'(stall_o), 32'd0);
    check("r5_issue_ok_after", 32'(issue_ok_o), 32'd1);
    check("r5_we_after", 32'(we_o), 32'd0);
    go();

    // Conflict: buffered r7 loses to the pipe for six cycles.
    idle_in();
    issue_i = 1'b1; issue_addr_i = 5'd7;
    go();
    idle_in();
    lu_valid_i = 1'b1; lu_addr_i = 5'd7; lu_data_i = 32'h7777;
    go();
    idle_in();
    chk_en1_i = 1'b1; chk_addr1_i = 5'd7;
    for (int k = 1; k <= 6; k++) begin
      pipe_valid_i = 1'b1;
      pipe_addr_i  = (k == 1) ? 5'd7 : 5'(10 + k);
      pipe_data_i  = 32'(k);
      mid();
      check("cf_we", 32'(we_o), 32'd1);
      check("cf_waddr", 32'(waddr_o), 32'(pipe_addr_i));
      check("cf_wdata", wdata_o, 32'(k));
      check("cf_lu_ready", 32'(lu_ready_o), 32'd0);
      check("cf_drain", 32'(drain_req_o), (k >= 5) ? 32'd1 : 32'd0);
      check("cf_stall_r7", 32'(stall_o), 32'd1);
      go();
    end
    pipe_valid_i = 1'b0; pipe_addr_i = 5'd0; pipe_data_i = 32'd0;
    mid();
    check("cf_bubble_we", 32'(we_o), 32'd1);
    check("cf_bubble_waddr", 32'(waddr_o), 32'd7);
    check("cf_bubble_wdata", wdata_o, 32'h7777);
    check("cf_bubble_stall", 32'(stall_o), 32'd0);
    go();
    mid();
    check("cf_drain_drop", 32'(drain_req_o), 32'd0);
    check("cf_stall_r7_clear", 32'(stall_o), 32'd0);
    go();

    // Back-to-back long-latency results r3 then r4.
    idle_in();
    lu_valid_i = 1'b1; lu_addr_i = 5'd3; lu_data_i = 32'h3333;
    mid();
    check("b2b_ready0", 32'(lu_ready_o), 32'd1);
    check("b2b_we0", 32'(we_o), 32'd0);
    go();
    lu_addr_i = 5'd4; lu_data_i = 32'h4444;
    mid();
    check("b2b_ready1", 32'(lu_ready_o), 32'd1);
    check("b2b_waddr1", 32'(waddr_o), 32'd3);
    check("b2b_wdata1", wdata_o, 32'h3333);
    go();
    lu_valid_i = 1'b0;
    mid();
    check("b2b_we2", 32'(we_o), 32'd1);
    check("b2b_waddr2", 32'(waddr_o), 32'd4);
    check("b2b_wdata2", wdata_o, 32'h4444);
    go();
    mid();
    check("b2b_we3", 32'(we_o), 32'd0);
    go();

    // Hazards on pending r9.
    idle_in();
    issue_i = 1'b1; issue_addr_i = 5'd9;
    go();
    idle_in();
    chk_en2_i = 1'b1; chk_addr2_i = 5'd9;
    mid(); check("hz_src2", 32'(stall_o), 32'd1);
    go();
    idle_in();
    chk_dst_en_i = 1'b1; chk_dst_i = 5'd9;
    issue_i = 1'b1; issue_addr_i = 5'd9;
    mid();
    check("hz_dst", 32'(stall_o), 32'd1);
    check("hz_issue_ok", 32'(issue_ok_o), 32'd0);
    go();
    idle_in();
    chk_addr1_i = 5'd9;
    lu_valid_i = 1'b1; lu_addr_i = 5'd9; lu_data_i = 32'h9999;
    mid(); check("hz_disabled_chk", 32'(stall_o), 32'd0);
    go();
    idle_in();
    go();
    chk_en1_i = 1'b1; chk_addr1_i = 5'd9; issue_addr_i = 5'd9;
    mid();
    check("hz_r9_cleared", 32'(stall_o), 32'd0);
    check("hz_r9_issue_ok", 32'(issue_ok_o), 32'd1);
    go();

    // r0 handling.
    idle_in();
    issue_i = 1'b1; issue_addr_i = 5'd0;
    mid(); check("r0_issue_ok", 32'(issue_ok_o), 32'd1);
    go();
    idle_in();
    chk_en1_i = 1'b1; chk_en2_i = 1'b1; chk_dst_en_i = 1'b1;
    lu_valid_i = 1'b1; lu_addr_i = 5'd0; lu_data_i = 32'hABCD;
    mid(); check("r0_no_stall", 32'(stall_o), 32'd0);
    go();
    lu_valid_i = 1'b0;
    mid();
    check("r0_we", 32'(we_o), 32'd1);
    check("r0_waddr", 32'(waddr_o), 32'd0);
    check("r0_wdata", wdata_o, 32'hABCD);
    go();

    // Reset mid-operation discards buffer and scoreboard.
    idle_in();
    issue_i = 1'b1; issue_addr_i = 5'd12;
    go();
    idle_in();
    pipe_valid_i = 1'b1; pipe_addr_i = 5'd1; pipe_data_i = 32'h1;
    lu_valid_i = 1'b1; lu_addr_i = 5'd12; lu_data_i = 32'hC0C0;
    go();
    idle_in();
    rst = 1'b1; pipe_valid_i = 1'b1; pipe_addr_i = 5'd1; pipe_data_i = 32'h2;
    mid();
    check("mr_rst_we", 32'(we_o), 32'd0);
    check("mr_rst_ready", 32'(lu_ready_o), 32'd0);
    go();
    idle_in();
    chk_en1_i = 1'b1; chk_addr1_i = 5'd12; issue_addr_i = 5'd12;
    mid();
    check("mr_idle_we", 32'(we_o), 32'd0);
    check("mr_idle_stall", 32'(stall_o), 32'd0);
    check("mr_idle_issue_ok", 32'(issue_ok_o), 32'd1);
    check("mr_idle_ready", 32'(lu_ready_o), 32'd1);
    check("mr_idle_drain", 32'(drain_req_o), 32'd0);
    go();

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
